// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between a fifo_sync read port, the reader and its stream consumer.
// Ports: iFifoEmpty/iFifoData/oFifoEnR (FIFO side), oValid/iReady/oData (stream), oBusy.
interface fifo_stream_reader_if #(
    parameter int BITWIDTH = 32
);
    logic                iFifoEmpty;
    logic [BITWIDTH-1:0] iFifoData;
    logic                oFifoEnR;
    logic                oValid;
    logic                iReady;
    logic [BITWIDTH-1:0] oData;
    logic                oBusy;

    modport master (
        input  iFifoEmpty,
        input  iFifoData,
        input  iReady,
        output oFifoEnR,
        output oValid,
        output oData,
        output oBusy
    );

    modport slave (
        output iFifoEmpty,
        output iFifoData,
        output iReady,
        input  oFifoEnR,
        input  oValid,
        input  oData,
        input  oBusy
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side master for fifo_sync: absorbs the 1-cycle read latency and re-presents
// words as a valid/ready stream through a 2-entry skid buffer.
// Ports: iClk, iRst (sync, active-high), iClr (sync flush), bus (master modport),
// oBeatCnt (only when FIFO_STREAM_READER_CNT_EN is defined).
module fifo_stream_reader #(
    parameter int BITWIDTH = 32,
    parameter int CNTWIDTH = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iClr,
    fifo_stream_reader_if.master bus
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    output logic [CNTWIDTH-1:0]  oBeatCnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                occ;
    occ_t                occ_nxt;
    logic                inflight;
    logic [BITWIDTH-1:0] buf0;
    logic [BITWIDTH-1:0] buf1;
    logic [BITWIDTH-1:0] buf0_nxt;
    logic [BITWIDTH-1:0] buf1_nxt;
    logic                pop;
    logic                enr;
    logic [2:0]          resv;
    logic                flush;

    if (CNTWIDTH < 1) begin : g_bad_cnt
        $error("CNTWIDTH must be at least 1");
    end

    assign flush = iRst | iClr;
    assign pop   = bus.oValid & bus.iReady;

    // Slots still claimed after this cycle's pop; a read may only be
    // issued when the returning word is guaranteed a free slot.
    assign resv = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign enr  = ~bus.iFifoEmpty & ~flush & (resv < 3'd2);

    assign bus.oFifoEnR = enr;
    assign bus.oValid   = (occ != EMPTY);
    assign bus.oData    = buf0;
    assign bus.oBusy    = (occ != EMPTY) | inflight;

    always_comb begin
        occ_nxt  = occ;
        buf0_nxt = buf0;
        buf1_nxt = buf1;
        if (flush) begin
            occ_nxt  = EMPTY;
            buf0_nxt = '0;
            buf1_nxt = '0;
        end else begin
            case ({pop, inflight})
                2'b10: begin
                    // Popping the last word keeps buf0 so oData holds.
                    if (occ == TWO) begin
                        buf0_nxt = buf1;
                        occ_nxt  = ONE;
                    end else begin
                        occ_nxt  = EMPTY;
                    end
                end
                2'b01: begin
                    if (occ == EMPTY) begin
                        buf0_nxt = bus.iFifoData;
                        occ_nxt  = ONE;
                    end else begin
                        buf1_nxt = bus.iFifoData;
                        occ_nxt  = TWO;
                    end
                end
                2'b11: begin
                    // Write slot is chosen after the shift.
                    if (occ == TWO) begin
                        buf0_nxt = buf1;
                        buf1_nxt = bus.iFifoData;
                    end else begin
                        buf0_nxt = bus.iFifoData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            occ      <= EMPTY;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            occ      <= occ_nxt;
            inflight <= enr;
            buf0     <= buf0_nxt;
            buf1     <= buf1_nxt;
        end
    end

`ifdef FIFO_STREAM_READER_CNT_EN
    always_ff @(posedge iClk) begin
        if (flush) begin
            oBeatCnt <= '0;
        end else if (pop) begin
            oBeatCnt <= oBeatCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small fifo_sync read-port model.
// Ports: none; drives the DUT through a fifo_stream_reader_if instance.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] fdata = '0;
    logic [31:0] mem [0:127];
    int          wp = 0;
    int          rp = 0;
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          viol = 0;
    int          nlog = 0;
    logic [31:0] blog [0:127];
`ifdef FIFO_STREAM_READER_CNT_EN
    logic [3:0]  cnt;
`endif

    fifo_stream_reader_if #(.BITWIDTH(32)) bus ();

    assign bus.iFifoEmpty = (wp == rp);
    assign bus.iFifoData  = fdata;

    fifo_stream_reader #(
        .BITWIDTH(32),
        .CNTWIDTH(4)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .iClr(clr),
        .bus (bus)
`ifdef FIFO_STREAM_READER_CNT_EN
        ,
        .oBeatCnt(cnt)
`endif
    );

    always #5 clk = ~clk;

    // fifo_sync read port: registered data the cycle after iEnR.
    always @(posedge clk) begin
        if (clr) begin
            rp <= wp;
        end else if (bus.oFifoEnR) begin
            fdata <= mem[rp];
            rp    <= rp + 1;
        end
    end

    always @(posedge clk) begin
        if (bus.oFifoEnR) rd_cnt <= rd_cnt + 1;
        if (bus.oFifoEnR && bus.iFifoEmpty) viol <= viol + 1;
        if (bus.oValid && bus.iReady) begin
            blog[nlog] <= bus.oData;
            nlog       <= nlog + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wp] = w;
        wp++;
    endtask

    task automatic drain(input int maxc);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!bus.oBusy && (wp == rp)) begin
                idle = 1'b1;
                break;
            end
        end
        chk("drain_done", {63'd0, idle}, 64'd1);
    endtask

    initial begin
        int r0;
        int l0;
        bus.iReady = 1'b0;

        // 1: reset with data waiting
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        #1;
        chk("rst_enr0", {63'd0, bus.oFifoEnR}, 64'd0);
        @(negedge clk);
        chk("rst_valid1", {63'd0, bus.oValid}, 64'd0);
        chk("rst_data1", {32'd0, bus.oData}, 64'd0);
        chk("rst_enr1", {63'd0, bus.oFifoEnR}, 64'd0);
        @(negedge clk);
        chk("rst_valid2", {63'd0, bus.oValid}, 64'd0);
        chk("rst_enr2", {63'd0, bus.oFifoEnR}, 64'd0);
        r0 = rd_cnt;
        rst = 1'b0;
        bus.iReady = 1'b1;
        #1;
        chk("first_enr", {63'd0, bus.oFifoEnR}, 64'd1);

        // 2: latency and full-rate streaming
        @(negedge clk);
        chk("lat_valid0", {63'd0, bus.oValid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream_valid", {63'd0, bus.oValid}, 64'd1);
            chk("stream_data", {32'd0, bus.oData}, 64'(32'h11 * (i + 1)));
        end
        @(negedge clk);
        chk("stream_end_valid", {63'd0, bus.oValid}, 64'd0);
        chk("stream_end_busy", {63'd0, bus.oBusy}, 64'd0);
        chk("stream_hold", {32'd0, bus.oData}, 64'h44);
        chk("stream_reads", 64'(rd_cnt - r0), 64'd4);

        // 3: long stall, buffer fills with 2 words only
        bus.iReady = 1'b0;
        r0 = rd_cnt;
        for (int i = 0; i < 8; i++) push(32'h101 + 32'(i));
        repeat (5) @(negedge clk);
        chk("stall_data5", {32'd0, bus.oData}, 64'h101);
        repeat (5) @(negedge clk);
        chk("stall_reads", 64'(rd_cnt - r0), 64'd2);
        chk("stall_valid", {63'd0, bus.oValid}, 64'd1);
        chk("stall_data10", {32'd0, bus.oData}, 64'h101);
        chk("stall_enr", {63'd0, bus.oFifoEnR}, 64'd0);
        l0 = nlog;
        bus.iReady = 1'b1;
        drain(40);
        chk("stall_beats", 64'(nlog - l0), 64'd8);
        for (int i = 0; i < 8; i++)
            chk("stall_order", {32'd0, blog[l0+i]}, 64'(32'h101 + 32'(i)));

        // 4: toggling ready
        l0 = nlog;
        for (int i = 0; i < 6; i++) push(32'h201 + 32'(i));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.iReady = ~bus.iReady;
            if (!bus.oBusy && (wp == rp)) break;
        end
        chk("tog_beats", 64'(nlog - l0), 64'd6);
        for (int i = 0; i < 6; i++)
            chk("tog_order", {32'd0, blog[l0+i]}, 64'(32'h201 + 32'(i)));
        chk("tog_busy", {63'd0, bus.oBusy}, 64'd0);

        // 5: clear with a word in flight
        @(negedge clk);
        bus.iReady = 1'b0;
        push(32'hA1); push(32'hA2);
        #1;
        chk("clr_pre_enr", {63'd0, bus.oFifoEnR}, 64'd1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_enr", {63'd0, bus.oFifoEnR}, 64'd0);
        chk("clr_inflight", {63'd0, bus.oBusy}, 64'd1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr_valid", {63'd0, bus.oValid}, 64'd0);
        chk("clr_data", {32'd0, bus.oData}, 64'd0);
        chk("clr_busy", {63'd0, bus.oBusy}, 64'd0);
        l0 = nlog;
        push(32'hB1);
        bus.iReady = 1'b1;
        drain(20);
        chk("clr_beats", 64'(nlog - l0), 64'd1);
        chk("clr_word", {32'd0, blog[l0]}, 64'hB1);

`ifdef FIFO_STREAM_READER_CNT_EN
        // 6: beat counter wrap
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("cnt_clr0", {60'd0, cnt}, 64'd0);
        for (int i = 0; i < 17; i++) push(32'h301 + 32'(i));
        drain(60);
        chk("cnt_wrap", {60'd0, cnt}, 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("cnt_clr1", {60'd0, cnt}, 64'd0);
`endif

        chk("enr_when_empty", 64'(viol), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
